// File: rtl/rover_drive_pkg.sv
// rtl/rover_drive_pkg.sv - shared state and H-bridge direction codes for the rover drive controller
// Contents:
//   state_t      3-bit state code, also exported on state_o
//   ST_*         state codes
//   DIR_*        per-side bridge pair {INa, INb}
package rover_drive_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FWD     = 3'd1;
    localparam state_t ST_BRAKE   = 3'd2;
    localparam state_t ST_REVERSE = 3'd3;
    localparam state_t ST_TURN    = 3'd4;
    localparam state_t ST_CHECK   = 3'd5;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_BRAKE = 2'b11;
    localparam logic [1:0] DIR_COAST = 2'b00;

endpackage

// File: rtl/rover_drive_ctrl_pwm_gen.sv
// rtl/rover_drive_ctrl_pwm_gen.sv - prescaled PWM generator with wrap-latched duty
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   duty         requested duty, sampled only when the counter wraps to 0
//   pwm          cnt < latched duty (combinational from registers)
module pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PWM_DIV  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_l;
    logic                pre_wrap;

    assign pre_wrap = (pre == PRE_W'(PWM_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            cnt    <= '0;
            duty_l <= '0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                cnt <= cnt + 1'b1;
                // Take the new duty only as a period starts so no runt pulse appears.
                if (cnt == '1)
                    duty_l <= duty;
            end
        end
    end

    assign pwm = (cnt < duty_l);

endmodule

// File: rtl/rover_drive_ctrl.sv
// rtl/rover_drive_ctrl.sv - dual H-bridge drive controller with timed obstacle escape
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   is_crash          obstacle-near level from the proximity stage
//   drive_en          1 = may move, 0 = coast (IDLE)
//   speed             forward duty
//   ena, enb          PWM enables, left/right bridge
//   in1,in2 / in3,in4 left / right direction pairs
//   state_o           current state code
//   escapes           saturating count of BRAKE entries
module rover_drive_ctrl
    import rover_drive_pkg::*;
#(
    parameter int                  PWM_BITS    = 8,
    parameter int                  PWM_DIV     = 16,
    parameter int                  CRASH_HOLD  = 1000,
    parameter int                  BRAKE_CYC   = 10_000_000,
    parameter int                  REVERSE_CYC = 50_000_000,
    parameter int                  TURN_CYC    = 40_000_000,
    parameter int                  SETTLE_CYC  = 10_000_000,
    parameter logic [PWM_BITS-1:0] ESCAPE_DUTY = 8'd160
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                is_crash,
    input  logic                drive_en,
    input  logic [PWM_BITS-1:0] speed,
    output logic                ena,
    output logic                enb,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    output logic                in4,
    output logic [2:0]          state_o,
    output logic [7:0]          escapes
);

    state_t              state;
    logic [31:0]         timer;
    logic [31:0]         crash_cnt;
    logic                crash_f;
    logic                timer_done;
    logic                pwm;
    logic [PWM_BITS-1:0] duty;
    logic                en_r;
    logic [1:0]          dir_l;
    logic [1:0]          dir_r;

    always_comb begin
        duty = '0;
        case (state)
            ST_FWD:              duty = speed;
            ST_REVERSE, ST_TURN: duty = ESCAPE_DUTY;
            default:             duty = '0;
        endcase
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (duty),
        .pwm   (pwm)
    );

    // Debounce: is_crash must be continuously high for CRASH_HOLD clocks.
    always_ff @(posedge clk) begin
        if (reset || !is_crash)
            crash_cnt <= '0;
        else if (crash_cnt != 32'(CRASH_HOLD))
            crash_cnt <= crash_cnt + 32'd1;
    end

    assign crash_f    = (crash_cnt == 32'(CRASH_HOLD));
    assign timer_done = (timer == 32'd0);

    // Timed states load N-1 on entry and leave on the edge where the timer is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            escapes <= '0;
        end else if (!drive_en) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!crash_f)
                        state <= ST_FWD;
                end
                ST_FWD: begin
                    if (crash_f) begin
                        state <= ST_BRAKE;
                        timer <= 32'(BRAKE_CYC - 1);
                        if (escapes != 8'hFF)
                            escapes <= escapes + 8'd1;
                    end
                end
                ST_BRAKE: begin
                    if (timer_done) begin
                        state <= ST_REVERSE;
                        timer <= 32'(REVERSE_CYC - 1);
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_REVERSE: begin
                    if (timer_done) begin
                        state <= ST_TURN;
                        timer <= 32'(TURN_CYC - 1);
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_TURN: begin
                    if (timer_done) begin
                        state <= ST_CHECK;
                        timer <= 32'(SETTLE_CYC - 1);
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_CHECK: begin
                    if (timer_done) begin
                        // Still blocked after settling: spin again without counting a new escape.
                        if (crash_f) begin
                            state <= ST_TURN;
                            timer <= 32'(TURN_CYC - 1);
                        end else begin
                            state <= ST_FWD;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Bridge outputs are registered from the current state, one clock behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r  <= 1'b0;
            dir_l <= DIR_COAST;
            dir_r <= DIR_COAST;
        end else begin
            case (state)
                ST_FWD: begin
                    en_r  <= pwm;
                    dir_l <= DIR_FWD;
                    dir_r <= DIR_FWD;
                end
                ST_BRAKE: begin
                    en_r  <= 1'b1;
                    dir_l <= DIR_BRAKE;
                    dir_r <= DIR_BRAKE;
                end
                ST_REVERSE: begin
                    en_r  <= pwm;
                    dir_l <= DIR_REV;
                    dir_r <= DIR_REV;
                end
                ST_TURN: begin
                    en_r  <= pwm;
                    dir_l <= DIR_FWD;
                    dir_r <= DIR_REV;
                end
                default: begin
                    en_r  <= 1'b0;
                    dir_l <= DIR_COAST;
                    dir_r <= DIR_COAST;
                end
            endcase
        end
    end

    assign ena     = en_r;
    assign enb     = en_r;
    assign in1     = dir_l[1];
    assign in2     = dir_l[0];
    assign in3     = dir_r[1];
    assign in4     = dir_r[0];
    assign state_o = state;

endmodule

// File: tb/tb_rover_drive_ctrl.sv
// tb/tb_rover_drive_ctrl.sv - scoreboard bench for rover_drive_ctrl against a cycle-count reference model
module tb_rover_drive_ctrl;

    localparam int PB      = 4;
    localparam int DIV     = 1;
    localparam int HOLD    = 3;
    localparam int N_BRAKE = 4;
    localparam int N_REV   = 6;
    localparam int N_TURN  = 5;
    localparam int N_SET   = 3;
    localparam int E_DUTY  = 8;
    localparam int STEPS   = 1 << PB;
    localparam int PER     = DIV * STEPS;

    localparam int S_IDLE  = 0;
    localparam int S_FWD   = 1;
    localparam int S_BRAKE = 2;
    localparam int S_REV   = 3;
    localparam int S_TURN  = 4;
    localparam int S_CHECK = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       is_crash = 1'b0;
    logic       drive_en = 1'b0;
    logic [3:0] speed = 4'd0;
    logic       ena, enb, in1, in2, in3, in4;
    logic [2:0] state_o;
    logic [7:0] escapes;

    always #5 clk = ~clk;

    rover_drive_ctrl #(
        .PWM_BITS    (PB),
        .PWM_DIV     (DIV),
        .CRASH_HOLD  (HOLD),
        .BRAKE_CYC   (N_BRAKE),
        .REVERSE_CYC (N_REV),
        .TURN_CYC    (N_TURN),
        .SETTLE_CYC  (N_SET),
        .ESCAPE_DUTY (4'd8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .is_crash (is_crash),
        .drive_en (drive_en),
        .speed    (speed),
        .ena      (ena),
        .enb      (enb),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .state_o  (state_o),
        .escapes  (escapes)
    );

    logic [16:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: state plus clocks still to spend in it, crash run length,
    // time since reset (PWM phase) and the duty in force for the current period.
    int m_state = 0, m_left = 0, m_run = 0, m_esc = 0, m_t = 0, m_dl = 0;

    function automatic int duty_of(input int st, input int spd);
        if (st == S_FWD) return spd;
        if (st == S_REV || st == S_TURN) return E_DUTY;
        return 0;
    endfunction

    task automatic model_edge(input bit r, input bit c, input bit d, input int spd);
        logic [16:0] e;
        logic [3:0]  dirs;
        bit          pwm_v, cf, en;
        int          ns, nl, ne;
        if (r) begin
            m_state = S_IDLE; m_left = 0; m_run = 0; m_esc = 0; m_t = 0; m_dl = 0;
            e = '0;
        end else begin
            pwm_v = (((m_t / DIV) % STEPS) < m_dl);
            case (m_state)
                S_FWD:   begin dirs = 4'b1010; en = pwm_v; end
                S_BRAKE: begin dirs = 4'b1111; en = 1'b1;  end
                S_REV:   begin dirs = 4'b0101; en = pwm_v; end
                S_TURN:  begin dirs = 4'b1001; en = pwm_v; end
                default: begin dirs = 4'b0000; en = 1'b0;  end
            endcase
            cf = (m_run == HOLD);
            ns = m_state; nl = m_left; ne = m_esc;
            if (!d) begin
                ns = S_IDLE;
            end else begin
                case (m_state)
                    S_IDLE:  if (!cf) ns = S_FWD;
                    S_FWD:   if (cf) begin ns = S_BRAKE; nl = N_BRAKE; if (ne < 255) ne = ne + 1; end
                    S_BRAKE: if (m_left == 1) begin ns = S_REV; nl = N_REV; end else nl = m_left - 1;
                    S_REV:   if (m_left == 1) begin ns = S_TURN; nl = N_TURN; end else nl = m_left - 1;
                    S_TURN:  if (m_left == 1) begin ns = S_CHECK; nl = N_SET; end else nl = m_left - 1;
                    S_CHECK: if (m_left == 1) begin
                                 if (cf) begin ns = S_TURN; nl = N_TURN; end
                                 else ns = S_FWD;
                             end else nl = m_left - 1;
                    default: ns = S_IDLE;
                endcase
            end
            if (((m_t + 1) % PER) == 0) m_dl = duty_of(m_state, spd);
            m_run = c ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
            m_t = m_t + 1;
            m_state = ns; m_left = nl; m_esc = ne;
            e = {en, en, dirs, 3'(ns), 8'(ne)};
        end
        exp_q.push_back(e);
    endtask

    // Drive one clock's inputs away from the edge and queue what must appear after it.
    task automatic step(input bit r, input bit c, input bit d, input logic [3:0] s);
        @(negedge clk);
        reset = r; is_crash = c; drive_en = d; speed = s;
        model_edge(r, c, d, int'(s));
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [16:0] e, act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ena, enb, in1, in2, in3, in4, state_o, escapes};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got {en,en,in1234,st,esc}=%b_%b_%b_%0d_%0d expected %b_%b_%b_%0d_%0d",
                             cyc, act[16], act[15], act[14:11], act[10:8], act[7:0],
                             e[16], e[15], e[14:11], e[10:8], e[7:0]);
                end
            end
        end
    end

    initial begin : stimulus
        int         hi;
        int         waited;
        logic       c;
        logic [3:0] sp;

        // Reset and idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);

        // PWM duty 4, mid-period change to 12, then 0
        repeat (21) step(0, 0, 1, 4);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 4);
            hi += int'(ena);
        end
        check("duty4_high_count", hi, 4);
        repeat (7) step(0, 0, 1, 4);
        repeat (40) step(0, 0, 1, 12);
        repeat (36) step(0, 0, 1, 0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            hi += int'(ena);
        end
        check("duty0_high_count", hi, 0);

        // Crash glitch, then full escape with is_crash dropped in REVERSE
        sp = 4'($urandom_range(1, 15));
        repeat (2) step(0, 1, 1, sp);
        repeat (5) step(0, 0, 1, sp);
        repeat (10) step(0, 1, 1, sp);
        repeat (30) step(0, 0, 1, sp);

        // Persistent obstacle: CHECK -> TURN loop
        repeat (70) step(0, 1, 1, sp);
        repeat (30) step(0, 0, 1, sp);

        // Escape counter saturation: BRAKE entry, abort, resume
        for (int i = 0; i < 260; i++) begin
            repeat (4) step(0, 1, 1, sp);
            step(0, 0, 0, sp);
            repeat (3) step(0, 0, 1, sp);
        end
        step(0, 0, 1, sp);
        check("escapes_saturated", int'(escapes), 255);

        // Abort mid-REVERSE
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 1, sp);
        repeat (4) step(0, 1, 1, sp);
        repeat (6) step(0, 0, 1, sp);
        step(0, 0, 0, sp);
        repeat (6) step(0, 0, 1, sp);

        // drive_en drop coincident with crash_f in FWD
        repeat (3) step(0, 1, 1, sp);
        step(0, 1, 0, sp);
        repeat (6) step(0, 0, 1, sp);

        // Reset mid-TURN
        repeat (4) step(0, 1, 1, sp);
        repeat (12) step(0, 0, 1, sp);
        step(1, 0, 1, sp);
        repeat (4) step(0, 0, 1, sp);

        // Randomized traffic
        c = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            if ($urandom_range(0, 15) == 0) sp = 4'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, c, $urandom_range(0, 39) != 0, sp);
        end

        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
